// File: rtl/fir_tap_sequencer.sv
// Five-tap shift-and-add FIR with one shared approximate adder, stepped once per tap.
// A sample is accepted in IDLE, summed over five ACC cycles, then held in DONE until the consumer takes it.
module fir_tap_sequencer #(
    parameter int WIDTH = 16,
    parameter int K     = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dataout,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] d0, d1, d2, d3, d4;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] tap_op;
    logic [WIDTH-1:0] sum;
    logic [2:0]       idx;
    logic             accept;
    logic             last_tap;

    // The lowest K bit positions forward only their generate, so no carry ripples through them.
    function automatic logic [WIDTH-1:0] approx_add(input logic [WIDTH-1:0] a,
                                                     input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] s;
        logic             c;
        logic             p;
        logic             g;
        s = {WIDTH{1'b0}};
        c = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            p    = a[i] ^ b[i];
            g    = a[i] & b[i];
            s[i] = p ^ c;
            if (i < K) begin
                c = g;
            end else begin
                c = g | (p & c);
            end
        end
        return s;
    endfunction

    assign accept   = in_valid && (state == IDLE);
    assign last_tap = (state == ACC) && (idx == 3'd4);
    assign sum      = approx_add(acc, tap_op);

    // Tap operand select: older samples get smaller shifts.
    always_comb begin
        tap_op = {WIDTH{1'b0}};
        case (idx)
            3'd0:    tap_op = d0 >> 3'd5;
            3'd1:    tap_op = d1 >> 3'd4;
            3'd2:    tap_op = d2 >> 3'd3;
            3'd3:    tap_op = d3 >> 3'd2;
            3'd4:    tap_op = d4 >> 3'd1;
            default: tap_op = {WIDTH{1'b0}};
        endcase
    end

    // Next-state decode for the IDLE/ACC/DONE sequencer.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = ACC;
                end else begin
                    state_next = IDLE;
                end
            end
            ACC: begin
                if (last_tap) begin
                    state_next = DONE;
                end else begin
                    state_next = ACC;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end else begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register with status flags registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            in_ready  <= (state_next == IDLE);
            out_valid <= (state_next == DONE);
            busy      <= (state_next != IDLE);
        end
    end

    // Delay line, accumulator and result register; dataout only moves on the final tap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d0      <= {WIDTH{1'b0}};
            d1      <= {WIDTH{1'b0}};
            d2      <= {WIDTH{1'b0}};
            d3      <= {WIDTH{1'b0}};
            d4      <= {WIDTH{1'b0}};
            acc     <= {WIDTH{1'b0}};
            idx     <= 3'd0;
            dataout <= {WIDTH{1'b0}};
        end else if (accept) begin
            d0  <= x;
            d1  <= d0;
            d2  <= d1;
            d3  <= d2;
            d4  <= d3;
            acc <= {WIDTH{1'b0}};
            idx <= 3'd0;
        end else if (state == ACC) begin
            acc <= sum;
            idx <= idx + 3'd1;
            if (last_tap) begin
                dataout <= sum;
            end
        end
    end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed bench: one K=6 and one K=0 instance share stimulus; expected values are hand-computed.
module tb_fir_tap_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] x;

    logic        k6_in_ready, k6_out_valid, k6_busy;
    logic [15:0] k6_dataout;
    logic        k0_in_ready, k0_out_valid, k0_busy;
    logic [15:0] k0_dataout;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] r6, r0;

    fir_tap_sequencer #(.WIDTH(16), .K(6)) u_dut_k6 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(k6_in_ready), .x(x),
        .out_valid(k6_out_valid), .out_ready(out_ready), .dataout(k6_dataout), .busy(k6_busy)
    );

    fir_tap_sequencer #(.WIDTH(16), .K(0)) u_dut_k0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(k0_in_ready), .x(x),
        .out_valid(k0_out_valid), .out_ready(out_ready), .dataout(k0_dataout), .busy(k0_busy)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x         = 16'h0000;
        rst       = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Offer xs, wait for the result, check latency and complete the handshake.
    task automatic run_sample(input logic [15:0] xs, output logic [15:0] o6, output logic [15:0] o0);
        int lat;
        in_valid = 1'b1;
        x        = xs;
        tick();
        check_value("accept_busy", {31'd0, k6_busy}, 32'd1);
        in_valid = 1'b0;
        x        = 16'h0000;
        lat      = 0;
        while (!k6_out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check_value("latency", lat, 32'd5);
        check_value("k0_out_valid", {31'd0, k0_out_valid}, 32'd1);
        o6        = k6_dataout;
        o0        = k0_dataout;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_value("idle_after_hs", {31'd0, k6_busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] stream_x [6];
        logic [15:0] stream_e [6];
        logic [15:0] ones_e   [5];
        stream_x = '{16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        stream_e = '{16'h0400, 16'h0800, 16'h1000, 16'h2000, 16'h4000, 16'h0000};
        ones_e   = '{16'h07FF, 16'h17FE, 16'h37FD, 16'h77FC, 16'hF7FB};

        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x         = 16'h0000;
        #2;
        rst = 1'b1;
        #1;
        check_value("rst_in_ready", {31'd0, k6_in_ready}, 32'd1);
        check_value("rst_out_valid", {31'd0, k6_out_valid}, 32'd0);
        check_value("rst_busy", {31'd0, k6_busy}, 32'd0);
        check_value("rst_dataout", {16'd0, k6_dataout}, 32'h0);
        check_value("rst_k0_in_ready", {31'd0, k0_in_ready}, 32'd1);
        apply_reset();

        // Impulse walks through the taps; first accept lands on the first edge after reset.
        for (int i = 0; i < 6; i++) begin
            run_sample(stream_x[i], r6, r0);
            check_value("stream_k6", {16'd0, r6}, {16'd0, stream_e[i]});
            check_value("stream_k0", {16'd0, r0}, {16'd0, stream_e[i]});
        end

        apply_reset();
        run_sample(16'h0020, r6, r0);
        check_value("k6_0020", {16'd0, r6}, 32'h0001);
        check_value("k0_0020", {16'd0, r0}, 32'h0001);
        run_sample(16'h03E0, r6, r0);
        check_value("k6_03E0", {16'd0, r6}, 32'h0019);
        check_value("k0_03E0", {16'd0, r0}, 32'h0021);

        apply_reset();
        for (int i = 0; i < 5; i++) begin
            run_sample(16'hFFFF, r6, r0);
            check_value("ones_k0", {16'd0, r0}, {16'd0, ones_e[i]});
            if (i < 2) begin
                check_value("ones_k6", {16'd0, r6}, {16'd0, ones_e[i]});
            end
        end

        // Back-pressure in DONE while new samples are offered.
        apply_reset();
        in_valid = 1'b1;
        x        = 16'h8000;
        tick();
        in_valid = 1'b0;
        x        = 16'h0000;
        repeat (5) tick();
        check_value("bp_enter_done", {31'd0, k6_out_valid}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            x        = 16'h1234 + 16'(i) * 16'h0101;
            tick();
            check_value("bp_out_valid", {31'd0, k6_out_valid}, 32'd1);
            check_value("bp_dataout_k6", {16'd0, k6_dataout}, 32'h0400);
            check_value("bp_dataout_k0", {16'd0, k0_dataout}, 32'h0400);
            check_value("bp_in_ready", {31'd0, k6_in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        x         = 16'h5555;
        tick();
        check_value("hs_out_valid", {31'd0, k6_out_valid}, 32'd0);
        check_value("hs_busy", {31'd0, k6_busy}, 32'd0);
        check_value("hs_in_ready", {31'd0, k6_in_ready}, 32'd1);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        x         = 16'h0000;
        run_sample(16'h0000, r6, r0);
        check_value("bp_hist_k6", {16'd0, r6}, 32'h0800);
        check_value("bp_hist_k0", {16'd0, r0}, 32'h0800);

        // Asynchronous reset during the third ACC cycle.
        in_valid = 1'b1;
        x        = 16'h1234;
        tick();
        in_valid = 1'b0;
        x        = 16'h0000;
        tick();
        tick();
        check_value("mid_acc_busy", {31'd0, k6_busy}, 32'd1);
        check_value("mid_acc_dataout", {16'd0, k6_dataout}, 32'h0800);
        #2;
        rst = 1'b1;
        #1;
        check_value("arst_out_valid", {31'd0, k6_out_valid}, 32'd0);
        check_value("arst_busy", {31'd0, k6_busy}, 32'd0);
        check_value("arst_in_ready", {31'd0, k6_in_ready}, 32'd1);
        check_value("arst_dataout_k6", {16'd0, k6_dataout}, 32'h0);
        check_value("arst_dataout_k0", {16'd0, k0_dataout}, 32'h0);
        in_valid = 1'b1;
        x        = 16'hABCD;
        tick();
        check_value("rst_no_accept", {31'd0, k6_busy}, 32'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        x        = 16'h0000;
        run_sample(16'h8000, r6, r0);
        check_value("post_rst_k6", {16'd0, r6}, 32'h0400);
        check_value("post_rst_k0", {16'd0, r0}, 32'h0400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
